// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data memory with its memory-mapped peripheral page:
// register offsets (word index within the page), CTRL bit positions and decode result.
package dmem_mmio_pkg;

    localparam logic [2:0] OFF_SW   = 3'd0;
    localparam logic [2:0] OFF_LED  = 3'd1;
    localparam logic [2:0] OFF_EDGE = 3'd2;
    localparam logic [2:0] OFF_CNT  = 3'd3;
    localparam logic [2:0] OFF_CMP  = 3'd4;
    localparam logic [2:0] OFF_CTRL = 3'd5;
    localparam logic [2:0] OFF_STAT = 3'd6;
    localparam logic [2:0] OFF_RSVD = 3'd7;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTORELOAD  = 1;
    localparam int CTRL_IRQ_EN_TMR  = 2;
    localparam int CTRL_IRQ_EN_SW   = 3;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_PERIPH,
        DEC_NONE
    } dec_t;

endpackage

// File: rtl/mmio_timer.sv
// 32-bit free-running timer with compare, optional auto-reload and a sticky MATCH flag.
// The counter, compare, control and status registers live here; reads are muxed by the top.
module mmio_timer
    import dmem_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr,
    input  logic [2:0]  off,
    input  logic [31:0] wd,
    output logic [31:0] cnt,
    output logic [31:0] cmp,
    output logic [3:0]  ctrl,
    output logic        match
);

    logic hit;

    assign hit = ctrl[CTRL_EN] && (cnt == cmp);

    // A software write to CNT overrides both increment and reload; a new match beats a W1C.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            cmp   <= '1;
            ctrl  <= '0;
            match <= 1'b0;
        end else begin
            if (wr && off == OFF_CNT)
                cnt <= wd;
            else if (ctrl[CTRL_EN])
                cnt <= (hit && ctrl[CTRL_AUTORELOAD]) ? 32'd0 : cnt + 32'd1;

            if (wr && off == OFF_CMP)
                cmp <= wd;

            if (wr && off == OFF_CTRL)
                ctrl <= wd[3:0];

            if (hit)
                match <= 1'b1;
            else if (wr && off == OFF_STAT && wd[0])
                match <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// MEM-stage data port: byte-lane word RAM plus a peripheral page (switches, edge capture,
// LEDs, timer). Reads are combinational, writes land on the rising clock edge.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          SW_WIDTH    = 10,
    parameter int          LED_WIDTH   = 10,
    parameter logic [31:0] PERIPH_BASE = 32'hC000_0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [31:0]          a,
    input  logic [31:0]          wd,
    output logic [31:0]          rd,
    input  logic [SW_WIDTH-1:0]  switches,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 irq,
    output logic                 bus_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dec_t                dec;
    logic [2:0]          off;
    logic [AW-1:0]       idx;
    logic                periph_wr;
    logic [31:0]         mem [DEPTH_WORDS];
    logic [31:0]         periph_rd;
    logic [SW_WIDTH-1:0] sw_s1, sw_s2, sw_q, sw_edge, edge_clr;
    logic [31:0]         cnt, cmp;
    logic [3:0]          ctrl;
    logic                match;

    always_comb begin
        dec = DEC_NONE;
        if (a < 32'(DEPTH_WORDS * 4))
            dec = DEC_RAM;
        else if (a[31:5] == PERIPH_BASE[31:5])
            dec = DEC_PERIPH;
    end

    assign idx       = a[AW+1:2];
    assign off       = a[4:2];
    assign periph_wr = we && (dec == DEC_PERIPH) && (be != 4'b0000);
    assign edge_clr  = (periph_wr && off == OFF_EDGE) ? wd[SW_WIDTH-1:0] : '0;

    // RAM has no reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && we && dec == DEC_RAM) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_q    <= '0;
            sw_edge <= '0;
            leds    <= '0;
            bus_err <= 1'b0;
        end else begin
            sw_s1   <= switches;
            sw_s2   <= sw_s1;
            sw_q    <= sw_s2;
            sw_edge <= (sw_edge & ~edge_clr) | (sw_s2 & ~sw_q);
            if (periph_wr && off == OFF_LED)
                leds <= wd[LED_WIDTH-1:0];
            bus_err <= (dec == DEC_NONE);
        end
    end

    mmio_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (periph_wr),
        .off     (off),
        .wd      (wd),
        .cnt     (cnt),
        .cmp     (cmp),
        .ctrl    (ctrl),
        .match   (match)
    );

    always_comb begin
        periph_rd = '0;
        case (off)
            OFF_SW:   periph_rd = 32'(sw_s2);
            OFF_LED:  periph_rd = 32'(leds);
            OFF_EDGE: periph_rd = 32'(sw_edge);
            OFF_CNT:  periph_rd = cnt;
            OFF_CMP:  periph_rd = cmp;
            OFF_CTRL: periph_rd = 32'(ctrl);
            OFF_STAT: periph_rd = 32'(match);
            default:  periph_rd = '0;
        endcase

        rd = '0;
        if (dec == DEC_RAM)
            rd = mem[idx];
        else if (dec == DEC_PERIPH)
            rd = periph_rd;
    end

    assign irq = (ctrl[CTRL_IRQ_EN_TMR] & match) | (ctrl[CTRL_IRQ_EN_SW] & (|sw_edge));

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed plus randomized bench for dmem_mmio, checked against a register-level
// behavioural model of the RAM and peripheral page kept in this file.
module tb_dmem_mmio;

    localparam int          DEPTH = 64;
    localparam int          SWW   = 10;
    localparam int          LEDW  = 10;
    localparam logic [31:0] PBASE = 32'hC000_0000;

    localparam logic [31:0] A_SW   = PBASE + 32'h00;
    localparam logic [31:0] A_LED  = PBASE + 32'h04;
    localparam logic [31:0] A_EDGE = PBASE + 32'h08;
    localparam logic [31:0] A_CNT  = PBASE + 32'h0C;
    localparam logic [31:0] A_CMP  = PBASE + 32'h10;
    localparam logic [31:0] A_CTRL = PBASE + 32'h14;
    localparam logic [31:0] A_STAT = PBASE + 32'h18;

    logic            clk = 1'b0;
    logic            reset_n, we, irq, bus_err;
    logic [3:0]      be;
    logic [31:0]     a, wd, rd;
    logic [SWW-1:0]  switches;
    logic [LEDW-1:0] leds;

    int total  = 0;
    int passed = 0;

    // Reference state: what each architectural register should hold after the last edge.
    logic [31:0]     m_mem   [int];
    logic [3:0]      m_valid [int];
    logic [31:0]     m_cnt, m_cmp;
    logic [3:0]      m_ctrl;
    logic            m_match, m_buserr;
    logic [LEDW-1:0] m_leds;
    logic [SWW-1:0]  m_edge;
    logic [SWW-1:0]  m_pin_ago [3];

    dmem_mmio #(
        .DEPTH_WORDS (DEPTH),
        .SW_WIDTH    (SWW),
        .LED_WIDTH   (LEDW),
        .PERIPH_BASE (PBASE)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (we),
        .be       (be),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .switches (switches),
        .leds     (leds),
        .irq      (irq),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int region(input logic [31:0] addr);
        if (addr < DEPTH * 4) return 0;
        if ((addr & 32'hFFFF_FFE0) == PBASE) return 1;
        return 2;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int          r, idx;
        logic [2:0]  o;
        logic        wr, hit;
        logic [31:0] word;
        if (!reset_n) begin
            m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 0; m_match = 0;
            m_leds = 0; m_edge = 0; m_buserr = 0;
            for (int i = 0; i < 3; i++) m_pin_ago[i] = 0;
            return;
        end
        r  = region(a);
        o  = a[4:2];
        wr = we && r == 1 && be != 0;
        if (we && r == 0) begin
            idx = int'(a >> 2);
            if (!m_mem.exists(idx)) begin m_mem[idx] = 0; m_valid[idx] = 0; end
            word = m_mem[idx];
            for (int i = 0; i < 4; i++)
                if (be[i]) begin
                    word[8*i +: 8] = wd[8*i +: 8];
                    m_valid[idx][i] = 1'b1;
                end
            m_mem[idx] = word;
        end
        // Edge capture: synchronised value (2 edges ago) high while the one before it was low.
        m_edge = (m_edge & ~((wr && o == 3'd2) ? wd[SWW-1:0] : '0)) | (m_pin_ago[1] & ~m_pin_ago[2]);
        m_pin_ago[2] = m_pin_ago[1];
        m_pin_ago[1] = m_pin_ago[0];
        m_pin_ago[0] = switches;
        hit = m_ctrl[0] && (m_cnt == m_cmp);
        if (wr && o == 3'd3)  m_cnt = wd;
        else if (m_ctrl[0])   m_cnt = (hit && m_ctrl[1]) ? 0 : m_cnt + 1;
        if (hit)                           m_match = 1;
        else if (wr && o == 3'd6 && wd[0]) m_match = 0;
        if (wr && o == 3'd4) m_cmp  = wd;
        if (wr && o == 3'd5) m_ctrl = wd[3:0];
        if (wr && o == 3'd1) m_leds = wd[LEDW-1:0];
        m_buserr = (r == 2);
    endtask

    function automatic logic [31:0] exp_rd(output logic [31:0] mask);
        int idx;
        mask = 32'hFFFF_FFFF;
        case (region(a))
            0: begin
                idx  = int'(a >> 2);
                mask = 0;
                if (m_mem.exists(idx)) begin
                    for (int i = 0; i < 4; i++)
                        if (m_valid[idx][i]) mask[8*i +: 8] = 8'hFF;
                    return m_mem[idx];
                end
                return 0;
            end
            1: case (a[4:2])
                3'd0: return 32'(m_pin_ago[1]);
                3'd1: return 32'(m_leds);
                3'd2: return 32'(m_edge);
                3'd3: return m_cnt;
                3'd4: return m_cmp;
                3'd5: return 32'(m_ctrl);
                3'd6: return 32'(m_match);
                default: return 0;
            endcase
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic check_output(input string tag);
        logic [31:0] m, e;
        e = exp_rd(m);
        if (m != 0) check({tag, ".rd"}, rd & m, e & m);
        check({tag, ".leds"}, 32'(leds), 32'(m_leds));
        check({tag, ".irq"}, 32'(irq), 32'((m_ctrl[2] & m_match) | (m_ctrl[3] & (|m_edge))));
        check({tag, ".bus_err"}, 32'(bus_err), 32'(m_buserr));
    endtask

    task automatic apply_stimulus(input logic w, input logic [3:0] b, input logic [31:0] addr,
                                  input logic [31:0] data);
        we = w; be = b; a = addr; wd = data;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
        apply_stimulus(1'b1, 4'hF, addr, data);
        tick();
        apply_stimulus(1'b0, 4'h0, addr, 32'h0);
    endtask

    initial begin
        logic [31:0] seq_ar [8];
        logic [31:0] seq_wr [7];
        seq_ar = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
        seq_wr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};

        reset_n = 1'b0; switches = '0;
        apply_stimulus(1'b0, 4'h0, 32'h0, 32'h0);
        tick(); tick();
        reset_n = 1'b1;

        apply_stimulus(1'b0, 4'h0, A_CNT, 32'h0);
        check("reset.cnt", rd, 32'h0);
        check_output("reset");
        apply_stimulus(1'b0, 4'h0, A_CMP, 32'h0);
        check("reset.cmp", rd, 32'hFFFF_FFFF);
        apply_stimulus(1'b0, 4'h0, A_CTRL, 32'h0);
        check("reset.ctrl", rd, 32'h0);

        // Byte-lane merge
        wr_reg(32'h10, 32'h1122_3344);
        apply_stimulus(1'b1, 4'b0010, 32'h10, 32'hAABB_CCDD);
        tick();
        apply_stimulus(1'b0, 4'h0, 32'h10, 32'h0);
        check("bytelane.rd", rd, 32'h1122_CC44);
        check_output("bytelane");

        // LEDs and an unmapped write
        wr_reg(A_LED, 32'h3FF);
        check("led.leds", 32'(leds), 32'h3FF);
        check("led.rd", rd, 32'h3FF);
        apply_stimulus(1'b1, 4'hF, 32'h8000_0000, 32'h0);
        tick();
        check("unmapped.bus_err", 32'(bus_err), 32'h1);
        check("unmapped.rd", rd, 32'h0);
        check("unmapped.leds", 32'(leds), 32'h3FF);
        apply_stimulus(1'b0, 4'h0, 32'h10, 32'h0);
        tick();
        check("mapped.bus_err", 32'(bus_err), 32'h0);

        // Switch edge capture: three clocks from pin to EDGE
        apply_stimulus(1'b0, 4'h0, A_EDGE, 32'h0);
        switches = 10'h005;
        tick(); check("edge.t1", rd, 32'h0);
        tick(); check("edge.t2", rd, 32'h0);
        tick(); check("edge.t3", rd, 32'h5);
        wr_reg(A_EDGE, 32'h1);
        check("edge.w1c", rd, 32'h4);
        wr_reg(A_CTRL, 32'h8);
        check("edge.irq_on", 32'(irq), 32'h1);
        wr_reg(A_EDGE, 32'h4);
        check("edge.irq_off", 32'(irq), 32'h0);
        check_output("edge");

        // Timer with auto-reload
        wr_reg(A_CMP, 32'd5);
        wr_reg(A_CNT, 32'd0);
        wr_reg(A_CTRL, 32'h7);
        apply_stimulus(1'b0, 4'h0, A_CNT, 32'h0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ar.cnt%0d", k), rd, seq_ar[k]);
            check($sformatf("ar.irq%0d", k), 32'(irq), (k >= 6) ? 32'h1 : 32'h0);
            check_output("ar");
            tick();
        end
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(1'b1, 4'hF, A_STAT, 32'h1);
            tick();
            apply_stimulus(1'b0, 4'h0, A_STAT, 32'h0);
            check_output($sformatf("w1c%0d", k));
        end

        // Timer wrap without auto-reload
        wr_reg(A_CTRL, 32'h0);
        wr_reg(A_STAT, 32'h1);
        wr_reg(A_CMP, 32'd3);
        wr_reg(A_CNT, 32'hFFFF_FFFE);
        wr_reg(A_CTRL, 32'h1);
        for (int k = 0; k < 7; k++) begin
            apply_stimulus(1'b0, 4'h0, A_CNT, 32'h0);
            check($sformatf("wrap.cnt%0d", k), rd, seq_wr[k]);
            apply_stimulus(1'b0, 4'h0, A_STAT, 32'h0);
            check($sformatf("wrap.stat%0d", k), rd, (k == 6) ? 32'h1 : 32'h0);
            check_output("wrap");
            tick();
        end

        // Randomized traffic across RAM, peripheral page and unmapped space
        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [31:0] addr;
            kind = $urandom_range(0, 9);
            if (kind < 5)      addr = 32'($urandom_range(0, DEPTH * 4 - 1));
            else if (kind < 9) addr = PBASE | 32'($urandom_range(0, 31));
            else               addr = {2'b01, 30'($urandom)};
            if (n % 8 == 0) switches = SWW'($urandom);
            apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom), addr, $urandom);
            check_output("rnd");
            tick();
        end

        // Reset on the same edge as a RAM write, timer running
        wr_reg(32'h20, 32'h1234_5678);
        wr_reg(A_LED, 32'h2AA);
        wr_reg(A_CTRL, 32'h5);
        apply_stimulus(1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        apply_stimulus(1'b0, 4'h0, 32'h20, 32'h0);
        check("rst.ram", rd, 32'h1234_5678);
        check("rst.leds", 32'(leds), 32'h0);
        check("rst.irq", 32'(irq), 32'h0);
        check_output("rst");
        apply_stimulus(1'b0, 4'h0, A_CNT, 32'h0);
        check("rst.cnt", rd, 32'h0);
        apply_stimulus(1'b0, 4'h0, A_CMP, 32'h0);
        check("rst.cmp", rd, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
